// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: reset PC, HLT opcode and
// 2-bit branch history counter encodings with their saturating update.
package fetch_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [3:0]  OPC_HLT      = 4'hF;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  function automatic bht_cnt_e bht_update(input bht_cnt_e cnt, input logic taken);
    bht_cnt_e res;
    res = cnt;
    case (cnt)
      SNT:     res = taken ? WNT : SNT;
      WNT:     res = taken ? WT  : SNT;
      WT:      res = taken ? ST  : WNT;
      ST:      res = taken ? ST  : WT;
      default: res = WNT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BHT (2-bit counters) + BTB with a combinational lookup port
// and a registered train port; a same-entry read sees the pre-train value.
module branch_predictor
  import fetch_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:1] lookup_pc,
  output logic        lookup_taken,
  output logic [15:0] lookup_target,
  input  logic        train_en,
  input  logic [15:1] train_pc,
  input  logic        train_taken,
  input  logic [15:0] train_target
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 15 - IDX_W;

  logic [IDX_W-1:0] lk_idx, tr_idx;
  logic [TAG_W-1:0] lk_tag, tr_tag;

  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[15:IDX_W+1];
  assign tr_idx = train_pc[IDX_W:1];
  assign tr_tag = train_pc[15:IDX_W+1];

  logic [ENTRIES-1:0]            valid_vec;
  logic [ENTRIES-1:0][1:0]       bht_vec;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_vec;
  logic [ENTRIES-1:0][15:0]      target_vec;

  genvar gi;
  for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
    bht_cnt_e         bht_q, bht_d;
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      target_q, target_d;

    always_comb begin
      bht_d    = bht_q;
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (train_en && tr_idx == IDX_W'(gi)) begin
        bht_d = bht_update(bht_q, train_taken);
        // Not-taken resolutions leave the BTB entry intact.
        if (train_taken) begin
          valid_d  = 1'b1;
          tag_d    = tr_tag;
          target_d = train_target;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bht_q    <= WNT;
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
      end else begin
        bht_q    <= bht_d;
        valid_q  <= valid_d;
        tag_q    <= tag_d;
        target_q <= target_d;
      end
    end

    assign valid_vec[gi]  = valid_q;
    assign bht_vec[gi]    = bht_q;
    assign tag_vec[gi]    = tag_q;
    assign target_vec[gi] = target_q;
  end

  assign lookup_taken  = valid_vec[lk_idx] && (tag_vec[lk_idx] == lk_tag) && bht_vec[lk_idx][1];
  assign lookup_target = target_vec[lk_idx];

endmodule

// File: rtl/fetch_branch_predictor.sv
// IF stage: PC register, next-PC selection and redirect/flush generation
// around a BHT/BTB dynamic predictor trained from ID-stage resolution.
module fetch_branch_predictor #(
  parameter logic [15:0] RESET_PC = fetch_pkg::RESET_PC_DEF,
  parameter int          IDX_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        ID_is_branch,
  input  logic        ID_branch_taken,
  input  logic [15:0] ID_branch_target,
  input  logic        ID_branch_mispredicted,
  input  logic [15:0] IF_ID_pc_curr,
  input  logic [15:0] IF_ID_pc_next,
  input  logic [15:0] IF_ID_predicted_target,
  output logic [15:0] pc_curr,
  output logic [15:0] pc_next,
  output logic [15:0] pc_inst,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  output logic        flush,
  output logic        hlt_fetched
);

  import fetch_pkg::*;

  logic [15:0] pc_q, pc_d;
  logic        resolve, redirect;

  assign pc_curr     = pc_q;
  assign imem_addr   = pc_q;
  assign pc_next     = pc_q + 16'd2;
  assign pc_inst     = imem_data;
  assign hlt_fetched = (imem_data[15:12] == OPC_HLT);

  assign resolve  = ID_is_branch & ~stall;
  // A correctly predicted taken branch still redirects if its target moved.
  assign redirect = resolve & (ID_branch_mispredicted |
                    (ID_branch_taken & ~ID_branch_mispredicted &
                     (ID_branch_target != IF_ID_predicted_target)));
  assign flush    = redirect;

  branch_predictor #(.IDX_W(IDX_W)) u_bp (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_pc    (pc_q[15:1]),
    .lookup_taken (predicted_taken),
    .lookup_target(predicted_target),
    .train_en     (resolve),
    .train_pc     (IF_ID_pc_curr[15:1]),
    .train_taken  (ID_branch_taken),
    .train_target (ID_branch_target)
  );

  always_comb begin
    pc_d = pc_q;
    if (redirect)
      pc_d = ID_branch_taken ? ID_branch_target : IF_ID_pc_next;
    else if (stall || hlt_fetched)
      pc_d = pc_q;
    else
      pc_d = predicted_taken ? predicted_target : pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Directed table-driven bench for the fetch stage: one vector per cycle,
// then a hand-written asynchronous reset sequence mid-run.
module tb_fetch_branch_predictor;

  localparam logic [15:0] ADD = 16'h1234;
  localparam logic [15:0] BR  = 16'hC000;
  localparam logic [15:0] HLT = 16'hF000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = ADD;
  logic        ID_is_branch = 1'b0;
  logic        ID_branch_taken = 1'b0;
  logic [15:0] ID_branch_target = '0;
  logic        ID_branch_mispredicted = 1'b0;
  logic [15:0] IF_ID_pc_curr = '0;
  logic [15:0] IF_ID_pc_next = '0;
  logic [15:0] IF_ID_predicted_target = '0;
  logic [15:0] pc_curr, pc_next, pc_inst, predicted_target;
  logic        predicted_taken, flush, hlt_fetched;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_branch_predictor dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .stall                 (stall),
    .imem_addr             (imem_addr),
    .imem_data             (imem_data),
    .ID_is_branch          (ID_is_branch),
    .ID_branch_taken       (ID_branch_taken),
    .ID_branch_target      (ID_branch_target),
    .ID_branch_mispredicted(ID_branch_mispredicted),
    .IF_ID_pc_curr         (IF_ID_pc_curr),
    .IF_ID_pc_next         (IF_ID_pc_next),
    .IF_ID_predicted_target(IF_ID_predicted_target),
    .pc_curr               (pc_curr),
    .pc_next               (pc_next),
    .pc_inst               (pc_inst),
    .predicted_taken       (predicted_taken),
    .predicted_target      (predicted_target),
    .flush                 (flush),
    .hlt_fetched           (hlt_fetched)
  );

  typedef struct {
    logic        stall;
    logic [15:0] imem;
    logic        isb;
    logic        tkn;
    logic [15:0] tgt;
    logic        mis;
    logic [15:0] ifpc;
    logic [15:0] ifnext;
    logic [15:0] ifpt;
    logic [15:0] e_pc;
    logic        e_pt;
    logic        chk_tgt;
    logic [15:0] e_tgt;
    logic        e_flush;
    logic        e_hlt;
  } vec_t;

  vec_t tbl[$];
  vec_t post[$];

  function automatic vec_t mk(logic s, logic [15:0] im, logic isb, logic tkn, logic [15:0] tgt,
                              logic mis, logic [15:0] ifpc, logic [15:0] ifnext, logic [15:0] ifpt,
                              logic [15:0] e_pc, logic e_pt, logic chk_tgt, logic [15:0] e_tgt,
                              logic e_flush, logic e_hlt);
    vec_t v;
    v.stall = s; v.imem = im; v.isb = isb; v.tkn = tkn; v.tgt = tgt; v.mis = mis;
    v.ifpc = ifpc; v.ifnext = ifnext; v.ifpt = ifpt; v.e_pc = e_pc; v.e_pt = e_pt;
    v.chk_tgt = chk_tgt; v.e_tgt = e_tgt; v.e_flush = e_flush; v.e_hlt = e_hlt;
    return v;
  endfunction

  function automatic vec_t idle(logic [15:0] im, logic [15:0] e_pc, logic e_pt,
                                logic chk_tgt, logic [15:0] e_tgt, logic e_hlt);
    return mk(1'b0, im, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0,
              e_pc, e_pt, chk_tgt, e_tgt, 1'b0, e_hlt);
  endfunction

  // Not-taken mispredict of a dummy branch at 0x000E, used to steer the PC.
  function automatic vec_t steer(logic [15:0] im, logic [15:0] dest, logic [15:0] e_pc, logic e_hlt);
    return mk(1'b0, im, 1'b1, 1'b0, 16'h0, 1'b1, 16'h000E, dest, 16'h0,
              e_pc, 1'b0, 1'b0, 16'h0, 1'b1, e_hlt);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t v, input string tag);
    stall = v.stall; imem_data = v.imem; ID_is_branch = v.isb; ID_branch_taken = v.tkn;
    ID_branch_target = v.tgt; ID_branch_mispredicted = v.mis; IF_ID_pc_curr = v.ifpc;
    IF_ID_pc_next = v.ifnext; IF_ID_predicted_target = v.ifpt;
    #1;
    $display("%s pc=%h pt=%b tgt=%h flush=%b hlt=%b", tag, pc_curr, predicted_taken,
             predicted_target, flush, hlt_fetched);
    chk({tag, " pc_curr"}, pc_curr, v.e_pc);
    chk({tag, " imem_addr"}, imem_addr, v.e_pc);
    chk({tag, " pc_next"}, pc_next, v.e_pc + 16'd2);
    chk({tag, " pc_inst"}, pc_inst, v.imem);
    chk({tag, " predicted_taken"}, {15'b0, predicted_taken}, {15'b0, v.e_pt});
    chk({tag, " flush"}, {15'b0, flush}, {15'b0, v.e_flush});
    chk({tag, " hlt_fetched"}, {15'b0, hlt_fetched}, {15'b0, v.e_hlt});
    if (v.chk_tgt) chk({tag, " predicted_target"}, predicted_target, v.e_tgt);
    @(negedge clk);
  endtask

  initial begin
    // Sequential fetch, then a taken redirect to 0xFFFC to show the wrap.
    tbl.push_back(idle(ADD, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(idle(ADD, 16'h0002, 0, 0, 0, 0));
    tbl.push_back(mk(0, ADD, 1, 1, 16'hFFFC, 1, 16'h1002, 16'h1004, 16'h0000, 16'h0004, 0, 0, 0, 1, 0));
    tbl.push_back(idle(ADD, 16'hFFFC, 0, 0, 0, 0));
    tbl.push_back(idle(ADD, 16'hFFFE, 0, 0, 0, 0));
    tbl.push_back(idle(ADD, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(steer(ADD, 16'h0010, 16'h0002, 0));
    // Branch at 0x0010 -> 0x0040: first resolve mispredicts, then predicted taken.
    tbl.push_back(idle(BR, 16'h0010, 0, 0, 0, 0));
    tbl.push_back(mk(0, ADD, 1, 1, 16'h0040, 1, 16'h0010, 16'h0012, 16'h0000, 16'h0012, 0, 0, 0, 1, 0));
    tbl.push_back(steer(ADD, 16'h0010, 16'h0040, 0));
    tbl.push_back(idle(BR, 16'h0010, 1, 1, 16'h0040, 0));
    tbl.push_back(mk(0, ADD, 1, 1, 16'h0040, 0, 16'h0010, 16'h0012, 16'h0040, 16'h0040, 0, 0, 0, 0, 0));
    // Counter now ST; a not-taken resolve mispredicts but keeps prediction taken.
    tbl.push_back(steer(ADD, 16'h0010, 16'h0042, 0));
    tbl.push_back(idle(BR, 16'h0010, 1, 1, 16'h0040, 0));
    tbl.push_back(mk(0, ADD, 1, 0, 16'h0000, 1, 16'h0010, 16'h0012, 16'h0040, 16'h0040, 0, 0, 0, 1, 0));
    tbl.push_back(steer(ADD, 16'h0010, 16'h0012, 0));
    // Predicted taken to 0x0040, resolves taken to 0x0080: target changed.
    tbl.push_back(idle(BR, 16'h0010, 1, 1, 16'h0040, 0));
    tbl.push_back(mk(0, ADD, 1, 1, 16'h0080, 0, 16'h0010, 16'h0012, 16'h0040, 16'h0040, 0, 0, 0, 1, 0));
    tbl.push_back(steer(ADD, 16'h0010, 16'h0080, 0));
    tbl.push_back(idle(BR, 16'h0010, 1, 1, 16'h0080, 0));
    // Two stalled not-taken mispredicts: no redirect, no training.
    tbl.push_back(mk(1, ADD, 1, 0, 16'h0000, 1, 16'h0010, 16'h0012, 16'h0080, 16'h0080, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, ADD, 1, 0, 16'h0000, 1, 16'h0010, 16'h0012, 16'h0080, 16'h0080, 0, 0, 0, 0, 0));
    tbl.push_back(steer(ADD, 16'h0010, 16'h0080, 0));
    tbl.push_back(idle(BR, 16'h0010, 1, 1, 16'h0080, 0));
    // HLT at 0x0020 holds the PC until a redirect overrides it.
    tbl.push_back(steer(ADD, 16'h0020, 16'h0080, 0));
    tbl.push_back(idle(HLT, 16'h0020, 0, 0, 0, 1));
    tbl.push_back(idle(HLT, 16'h0020, 0, 0, 0, 1));
    tbl.push_back(steer(HLT, 16'h0030, 16'h0020, 1));
    tbl.push_back(idle(ADD, 16'h0030, 0, 0, 0, 0));

    // After the mid-run reset the predictor must be cold again.
    post.push_back(idle(ADD, 16'h0000, 0, 0, 0, 0));
    post.push_back(steer(ADD, 16'h0010, 16'h0002, 0));
    post.push_back(idle(BR, 16'h0010, 0, 0, 0, 0));
    post.push_back(idle(ADD, 16'h0012, 0, 0, 0, 0));

    #12;
    chk("reset pc_curr", pc_curr, 16'h0000);
    chk("reset predicted_taken", {15'b0, predicted_taken}, 16'h0);
    chk("reset flush", {15'b0, flush}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    #2;
    stall = 0; imem_data = ADD; ID_is_branch = 0; ID_branch_mispredicted = 0; ID_branch_taken = 0;
    rst_n = 1'b0;
    #1;
    $display("rst pulse pc=%h pt=%b flush=%b", pc_curr, predicted_taken, flush);
    chk("async reset pc_curr", pc_curr, 16'h0000);
    chk("async reset predicted_taken", {15'b0, predicted_taken}, 16'h0);
    chk("async reset flush", {15'b0, flush}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < post.size(); i++) apply(post[i], $sformatf("post%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
